pwrgood_monitor: RTL and testbench

- Upstream conditioner for the four user-domain power-good flags consumed by the system-control register block.
- Synchronizes each raw pwrgood input, debounces it with a programmable stable-count, and drives the clean flags downstream.
- Records rising/falling events in sticky write-1-to-clear bits and raises a maskable level interrupt.
- Software access uses the same iomem valid/ready register bus as the system-control block.

---
 rtl/pwrgood_pkg.sv | 37 +++
 rtl/pwrgood_monitor_if.sv | 21 ++
 rtl/pwrgood_debounce.sv | 61 ++++++
 rtl/pwrgood_monitor.sv | 92 +++++++++
 tb/tb_pwrgood_monitor.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwrgood_pkg.sv
// Shared constants for the power-good monitor: register map, debounce sizing
// and EVENTS field layout.
package pwrgood_pkg;

    localparam int NUM_CH = 4;
    localparam int DB_W   = 8;

    localparam logic [DB_W-1:0] DB_RST   = 8'd16;
    localparam logic [31:0]     BASE_ADR = 32'h2F00_0100;

    localparam logic [7:0] OFS_STATUS   = 8'h00;
    localparam logic [7:0] OFS_EVENTS   = 8'h04;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h08;
    localparam logic [7:0] OFS_DEBOUNCE = 8'h0c;

    localparam int FALL_LSB = 0;
    localparam int RISE_LSB = 4;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_EVENTS,
        REG_IRQ_EN,
        REG_DEBOUNCE,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [7:0] ofs);
        case (ofs)
            OFS_STATUS:   return REG_STATUS;
            OFS_EVENTS:   return REG_EVENTS;
            OFS_IRQ_EN:   return REG_IRQ_EN;
            OFS_DEBOUNCE: return REG_DEBOUNCE;
            default:      return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pwrgood_monitor_if.sv
// iomem valid/ready register bus shared with the system-control block.
interface pwrgood_monitor_if;

    logic [31:0] iomem_addr;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;

    modport master (
        output iomem_addr, iomem_valid, iomem_wstrb, iomem_wdata,
        input  iomem_rdata, iomem_ready
    );

    modport slave (
        input  iomem_addr, iomem_valid, iomem_wstrb, iomem_wdata,
        output iomem_rdata, iomem_ready
    );

endinterface

// File: rtl/pwrgood_debounce.sv
// One power-good channel: two-flop synchronizer, stable-count debounce and
// single-cycle rise/fall indications aligned with the output change.
module pwrgood_debounce
    import pwrgood_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            raw,
    input  logic [DB_W-1:0] db_len,
    input  logic            cnt_clr,
    output logic            out,
    output logic            rise,
    output logic            fall
);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            out_q, out_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [DB_W-1:0] last_cnt;

    // A length of zero is treated as one, so the terminal count is never negative.
    always_comb begin
        last_cnt = (db_len == '0) ? '0 : db_len - DB_W'(1);
        s1_d     = raw;
        s2_d     = s1_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        fall     = 1'b0;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s2_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == last_cnt) begin
            out_d = s2_q;
            cnt_d = '0;
            rise  = s2_q;
            fall  = ~s2_q;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            out_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pwrgood_monitor.sv
// Power-good conditioner: four debounced channels plus the status/event/irq
// register page on the iomem bus.
module pwrgood_monitor
    import pwrgood_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    pwrgood_monitor_if.slave  bus,
    input  logic [NUM_CH-1:0] pwrgood_raw,
    output logic [NUM_CH-1:0] pwrgood_out,
    output logic              pwr_irq
);

    logic [NUM_CH-1:0] ch_out, ch_rise, ch_fall;
    logic [7:0]        events_q, events_d;
    logic [7:0]        irq_en_q, irq_en_d;
    logic [DB_W-1:0]   debounce_q, debounce_d;
    logic              irq_q, irq_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              accept, wr_en, db_wr;
    reg_sel_e          sel;
    logic [31:0]       rd_val;
    logic [7:0]        ev_set, ev_clr;
    logic              unused_bus_bits;

    assign accept = bus.iomem_valid && !ready_q
                    && (bus.iomem_addr[31:8] == BASE_ADR[31:8]);
    assign sel    = decode_offset(bus.iomem_addr[7:0]);
    assign wr_en  = accept && bus.iomem_wstrb[0];
    assign db_wr  = wr_en && (sel == REG_DEBOUNCE);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwrgood_debounce u_db (
            .clk     (clk),
            .resetn  (resetn),
            .raw     (pwrgood_raw[i]),
            .db_len  (debounce_q),
            .cnt_clr (db_wr),
            .out     (ch_out[i]),
            .rise    (ch_rise[i]),
            .fall    (ch_fall[i])
        );
    end

    // New events are ORed in after the W1C mask, so a same-cycle set beats a clear.
    always_comb begin
        ev_set                         = '0;
        ev_set[RISE_LSB +: NUM_CH]     = ch_rise;
        ev_set[FALL_LSB +: NUM_CH]     = ch_fall;
        ev_clr                         = (wr_en && sel == REG_EVENTS) ? bus.iomem_wdata[7:0] : 8'h00;
        events_d                       = (events_q & ~ev_clr) | ev_set;
        irq_en_d                       = (wr_en && sel == REG_IRQ_EN) ? bus.iomem_wdata[7:0] : irq_en_q;
        debounce_d                     = db_wr ? bus.iomem_wdata[DB_W-1:0] : debounce_q;
        irq_d                          = |(events_q & irq_en_q);
        ready_d                        = accept;
        case (sel)
            REG_STATUS:   rd_val = {28'd0, ch_out};
            REG_EVENTS:   rd_val = {24'd0, events_q};
            REG_IRQ_EN:   rd_val = {24'd0, irq_en_q};
            REG_DEBOUNCE: rd_val = 32'(debounce_q);
            default:      rd_val = 32'd0;
        endcase
        rdata_d                        = accept ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            events_q   <= '0;
            irq_en_q   <= '0;
            debounce_q <= DB_RST;
            irq_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            events_q   <= events_d;
            irq_en_q   <= irq_en_d;
            debounce_q <= debounce_d;
            irq_q      <= irq_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign unused_bus_bits = ^{bus.iomem_wdata[31:8], bus.iomem_wstrb[3:1]};

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign pwrgood_out     = ch_out;
    assign pwr_irq         = irq_q;

endmodule

// File: tb/tb_pwrgood_monitor.sv
// Directed bench for pwrgood_monitor: register access, debounce latency and
// glitch rejection, W1C events, interrupt timing and reset behaviour.
module tb_pwrgood_monitor;

    logic        clk;
    logic        resetn;
    logic [3:0]  pwrgood_raw;
    logic [3:0]  pwrgood_out;
    logic        pwr_irq;
    int          total;
    int          bad;
    logic [31:0] rd;
    logic        seen_ready;

    localparam logic [31:0] A_STATUS   = 32'h2F00_0100;
    localparam logic [31:0] A_EVENTS   = 32'h2F00_0104;
    localparam logic [31:0] A_IRQ_EN   = 32'h2F00_0108;
    localparam logic [31:0] A_DEBOUNCE = 32'h2F00_010C;
    localparam logic [31:0] A_UNMAPPED = 32'h2F00_0110;
    localparam logic [31:0] A_OUTSIDE  = 32'h2F00_0204;

    pwrgood_monitor_if bus ();

    pwrgood_monitor dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.slave),
        .pwrgood_raw (pwrgood_raw),
        .pwrgood_out (pwrgood_out),
        .pwr_irq     (pwr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus access; the ack must arrive on the first edge and last one cycle.
    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int lat;
        lat = 0;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = wstrb;
        bus.iomem_wdata = wdata;
        bus.iomem_valid = 1'b1;
        do begin
            tick(1);
            lat++;
        end while (!bus.iomem_ready && lat < 4);
        check_output("ack_latency", 32'(lat), 32'd1);
        rdata = bus.iomem_rdata;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick(1);
        check_output("ack_pulse_end", 32'(bus.iomem_ready), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn          = 1'b0;
        pwrgood_raw     = 4'h0;
        bus.iomem_addr  = '0;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_wdata = '0;
        tick(3);
        resetn = 1'b1;

        $display("[TB] reset values");
        check_output("rst_out",   32'(pwrgood_out), 32'h0);
        check_output("rst_irq",   32'(pwr_irq), 32'h0);
        check_output("rst_ready", 32'(bus.iomem_ready), 32'h0);
        check_output("rst_rdata", bus.iomem_rdata, 32'h0);
        bus_xfer(A_STATUS,   4'h0, 32'h0, rd); check_output("rst_status",   rd, 32'h0);
        bus_xfer(A_EVENTS,   4'h0, 32'h0, rd); check_output("rst_events",   rd, 32'h0);
        bus_xfer(A_IRQ_EN,   4'h0, 32'h0, rd); check_output("rst_irq_en",   rd, 32'h0);
        bus_xfer(A_DEBOUNCE, 4'h0, 32'h0, rd); check_output("rst_debounce", rd, 32'd16);

        $display("[TB] register access");
        bus_xfer(A_STATUS,   4'hF, 32'hF, rd);
        bus_xfer(A_STATUS,   4'h0, 32'h0, rd); check_output("status_ro", rd, 32'h0);
        bus_xfer(A_UNMAPPED, 4'hF, 32'hFFFF_FFFF, rd); check_output("unmapped_wr_rdata", rd, 32'h0);
        bus_xfer(A_UNMAPPED, 4'h0, 32'h0, rd); check_output("unmapped_rdata", rd, 32'h0);
        bus_xfer(A_IRQ_EN,   4'h1, 32'h55, rd); check_output("irq_en_prewrite0", rd, 32'h0);
        bus_xfer(A_IRQ_EN,   4'h2, 32'hAA00, rd); check_output("irq_en_prewrite1", rd, 32'h55);
        bus_xfer(A_IRQ_EN,   4'h1, 32'h00, rd); check_output("irq_en_wstrb_gate", rd, 32'h55);
        bus_xfer(A_IRQ_EN,   4'h0, 32'h0, rd); check_output("irq_en_cleared", rd, 32'h0);

        bus.iomem_addr  = A_OUTSIDE;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_valid = 1'b1;
        seen_ready      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            seen_ready |= bus.iomem_ready;
        end
        check_output("outside_no_ack", 32'(seen_ready), 32'h0);
        bus.iomem_valid = 1'b0;
        tick(1);

        $display("[TB] debounce latency");
        bus_xfer(A_DEBOUNCE, 4'h1, 32'd4, rd);
        pwrgood_raw[0] = 1'b1;
        tick(5); check_output("ch0_before_edge6", 32'(pwrgood_out), 32'h0);
        tick(1); check_output("ch0_at_edge6",     32'(pwrgood_out), 32'h1);
        bus_xfer(A_EVENTS, 4'h0, 32'h0, rd); check_output("ch0_rise_event", rd, 32'h10);
        bus_xfer(A_EVENTS, 4'h1, 32'hFF, rd);

        $display("[TB] glitch rejection");
        pwrgood_raw[2] = 1'b1;
        tick(6); check_output("ch2_high", 32'(pwrgood_out), 32'h5);
        bus_xfer(A_EVENTS, 4'h1, 32'hFF, rd);
        pwrgood_raw[2] = 1'b0;
        tick(3);
        pwrgood_raw[2] = 1'b1;
        tick(10); check_output("ch2_glitch3_out", 32'(pwrgood_out), 32'h5);
        bus_xfer(A_EVENTS, 4'h0, 32'h0, rd); check_output("ch2_glitch3_events", rd, 32'h0);
        pwrgood_raw[2] = 1'b0;
        tick(4);
        pwrgood_raw[2] = 1'b1;
        tick(2); check_output("ch2_pulse4_out", 32'(pwrgood_out), 32'h1);
        bus_xfer(A_EVENTS, 4'h0, 32'h0, rd); check_output("ch2_fall_event", rd, 32'h04);
        tick(4); check_output("ch2_recovered", 32'(pwrgood_out), 32'h5);
        bus_xfer(A_EVENTS, 4'h1, 32'hFF, rd);

        $display("[TB] interrupt");
        pwrgood_raw[1] = 1'b1;
        tick(6); check_output("ch1_high", 32'(pwrgood_out), 32'h7);
        bus_xfer(A_IRQ_EN, 4'h1, 32'h0F, rd);
        bus_xfer(A_EVENTS, 4'h1, 32'hFF, rd);
        check_output("irq_rise_masked", 32'(pwr_irq), 32'h0);
        pwrgood_raw[1] = 1'b0;
        tick(6);
        check_output("ch1_fell",         32'(pwrgood_out), 32'h5);
        check_output("irq_lags_event",   32'(pwr_irq), 32'h0);
        tick(1); check_output("irq_set", 32'(pwr_irq), 32'h1);
        bus.iomem_addr  = A_EVENTS;
        bus.iomem_wstrb = 4'h1;
        bus.iomem_wdata = 32'h02;
        bus.iomem_valid = 1'b1;
        tick(1);
        check_output("irq_clr_ack",      32'(bus.iomem_ready), 32'h1);
        check_output("irq_held_at_clr",  32'(pwr_irq), 32'h1);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick(1); check_output("irq_cleared", 32'(pwr_irq), 32'h0);
        bus_xfer(A_EVENTS, 4'h0, 32'h0, rd); check_output("events_after_w1c", rd, 32'h0);

        $display("[TB] set beats clear");
        pwrgood_raw[3] = 1'b1;
        tick(6); check_output("ch3_high", 32'(pwrgood_out), 32'hD);
        bus_xfer(A_EVENTS, 4'h1, 32'hFF, rd);
        pwrgood_raw[3] = 1'b0;
        tick(5);
        bus.iomem_addr  = A_EVENTS;
        bus.iomem_wstrb = 4'h1;
        bus.iomem_wdata = 32'h08;
        bus.iomem_valid = 1'b1;
        tick(1);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick(1);
        check_output("ch3_fell", 32'(pwrgood_out), 32'h5);
        bus_xfer(A_EVENTS, 4'h0, 32'h0, rd); check_output("set_wins", rd, 32'h08);
        check_output("irq_from_fall3", 32'(pwr_irq), 32'h1);
        bus_xfer(A_EVENTS, 4'h1, 32'hFF, rd);

        $display("[TB] debounce write restarts counters");
        pwrgood_raw[0] = 1'b0;
        tick(4);
        bus_xfer(A_DEBOUNCE, 4'h1, 32'd4, rd);
        check_output("dbwr_hold_e6", 32'(pwrgood_out), 32'h5);
        tick(2); check_output("dbwr_hold_e8", 32'(pwrgood_out), 32'h5);
        tick(1); check_output("dbwr_fall_e9", 32'(pwrgood_out), 32'h4);

        $display("[TB] reset mid-count");
        pwrgood_raw = 4'h1;
        tick(3);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        check_output("rst2_out",   32'(pwrgood_out), 32'h0);
        check_output("rst2_irq",   32'(pwr_irq), 32'h0);
        check_output("rst2_rdata", bus.iomem_rdata, 32'h0);
        bus_xfer(A_STATUS,   4'h0, 32'h0, rd); check_output("rst2_status",   rd, 32'h0);
        bus_xfer(A_EVENTS,   4'h0, 32'h0, rd); check_output("rst2_events",   rd, 32'h0);
        bus_xfer(A_IRQ_EN,   4'h0, 32'h0, rd); check_output("rst2_irq_en",   rd, 32'h0);
        bus_xfer(A_DEBOUNCE, 4'h0, 32'h0, rd); check_output("rst2_debounce", rd, 32'd16);
        tick(9);  check_output("rst2_ch0_e17", 32'(pwrgood_out), 32'h0);
        tick(1);  check_output("rst2_ch0_e18", 32'(pwrgood_out), 32'h1);

        $display("[TB] debounce of zero acts as one");
        bus_xfer(A_DEBOUNCE, 4'h1, 32'd0, rd);
        bus_xfer(A_DEBOUNCE, 4'h0, 32'h0, rd); check_output("db_zero_readback", rd, 32'h0);
        pwrgood_raw[3] = 1'b1;
        tick(2); check_output("db0_e2", 32'(pwrgood_out), 32'h1);
        tick(1); check_output("db0_e3", 32'(pwrgood_out), 32'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
